// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine with 7-segment display.
//   state_t      : controller states
//   SEG_DIGITS   : active-low segment patterns for BCD 0..9 (bit 7 = dp, held off)
//   SEG_BLANK    : all segments off
//   seg_decode() : BCD digit to segment pattern, blank for non-decimal codes
//   idx_width()  : bits needed to index n items (at least 1)
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  // Segments a..g in bits 0..6, dp in bit 7; a 0 lights the segment.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
    if (bcd > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[bcd];
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 7-segment driver: converts value to DIGITS BCD digits (leading
// zeros shown) and scans them LSD to MSD, one digit per scan pulse.
// Ports:
//   sys_clk, reset : clock, async active-high reset
//   value          : binary value to display
//   seg_out        : active-low segments, dp in bit 7 (always off)
//   seg_sel        : active-low one-hot digit select, all 1s until first scan
module seg_scan
  import vend_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] seg_sel
);

  localparam int IW = idx_width(DIGITS);

  logic [SCAN_DIV-1:0]     scan_cnt;
  logic                    scan;
  logic                    started;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_next;
  logic [DIGITS-1:0][3:0]  bcd;
  logic [WIDTH-1:0]        rem;

  // Free-running down-counter; the terminal count is the scan enable.
  assign scan = (scan_cnt == '0);

  always_comb begin
    rem = value;
    bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[i] = 4'(rem % WIDTH'(10));
      rem    = rem / WIDTH'(10);
    end
  end

  // The first scan after reset always lands on digit 0.
  always_comb begin
    if (!started || idx == IW'(DIGITS - 1)) idx_next = '0;
    else                                    idx_next = idx + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      started  <= 1'b0;
      idx      <= '0;
      seg_sel  <= '1;
      seg_out  <= SEG_BLANK;
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
      if (scan) begin
        started <= 1'b1;
        idx     <= idx_next;
        seg_sel <= ~(DIGITS'(1) << idx_next);
        seg_out <= seg_decode(bcd[idx_next]);
      end
    end
  end

endmodule

// File: rtl/vending_machine_seg.sv
// Coin-operated vending controller with a multiplexed 7-segment credit display.
// Optional feature macro: VEND_CHANGE_EN (change/refund outputs). Without it the
// change outputs stay 0, excess credit is forfeited and cancel only clears credit.
// Ports:
//   sys_clk, reset       : clock, async active-high reset
//   c, a                 : coin-present level (async) and coin value
//   cancel               : refund request level (async)
//   d                    : dispense strobe, one tick period
//   change, change_valid : change/refund amount and qualifier
//   seg_out, seg_sel     : display segments and digit select, active-low
//
// state     | meaning
// ST_IDLE   | no credit, waiting for a coin
// ST_ACCUM  | credit held, accepting coins / cancel
// ST_VEND   | dispense pulse and change for one tick
// ST_REFUND | refund of credit for one tick
module vending_machine_seg
  import vend_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] PRICE    = WIDTH'(150),
  parameter int               DIGITS   = 4,
  parameter int               TICK_DIV = 24,
  parameter int               SCAN_DIV = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              c,
  input  logic [WIDTH-1:0]  a,
  input  logic              cancel,
  output logic              d,
  output logic [WIDTH-1:0]  change,
  output logic              change_valid,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] seg_sel
);

  logic                c_meta, c_sync, c_prev;
  logic                cancel_meta, cancel_sync;
  logic [TICK_DIV-1:0] tick_cnt;
  logic                tick;
  logic                coin_ok;
  logic [WIDTH:0]      sum_wide;
  logic [WIDTH-1:0]    credit;
  state_t              state;
  logic [WIDTH-1:0]    tot;

  assign tick = (tick_cnt == '0);

  // c_prev holds the synchronised coin level from the previous tick, so a coin
  // held across many ticks is credited only once.
  always_comb begin
    coin_ok  = tick && c_sync && !c_prev;
    sum_wide = {1'b0, tot} + {1'b0, a};
    if (!coin_ok)            credit = tot;
    else if (sum_wide[WIDTH]) credit = '1;
    else                     credit = sum_wide[WIDTH-1:0];
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      c_meta       <= 1'b0;
      c_sync       <= 1'b0;
      c_prev       <= 1'b0;
      cancel_meta  <= 1'b0;
      cancel_sync  <= 1'b0;
      tick_cnt     <= '0;
      state        <= ST_IDLE;
      tot          <= '0;
      d            <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
    end else begin
      c_meta      <= c;
      c_sync      <= c_meta;
      cancel_meta <= cancel;
      cancel_sync <= cancel_meta;
      tick_cnt    <= tick_cnt - 1'b1;
      if (tick) begin
        c_prev <= c_sync;
        case (state)
          ST_IDLE, ST_ACCUM: begin
            // A coin arriving on the vend tick is ignored, not credited.
            if (state == ST_ACCUM && tot >= PRICE) begin
              state <= ST_VEND;
              d     <= 1'b1;
              tot   <= '0;
`ifdef VEND_CHANGE_EN
              change       <= tot - PRICE;
              change_valid <= 1'b1;
`endif
            end else if (cancel_sync && (coin_ok || state == ST_ACCUM)) begin
              tot <= '0;
`ifdef VEND_CHANGE_EN
              state        <= ST_REFUND;
              change       <= credit;
              change_valid <= 1'b1;
`else
              state <= ST_IDLE;
`endif
            end else if (coin_ok) begin
              tot   <= credit;
              state <= ST_ACCUM;
            end
          end
          ST_VEND, ST_REFUND: begin
            state        <= ST_IDLE;
            d            <= 1'b0;
            change       <= '0;
            change_valid <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  seg_scan #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .sys_clk (sys_clk),
    .reset   (reset),
    .value   (tot),
    .seg_out (seg_out),
    .seg_sel (seg_sel)
  );

endmodule

// File: tb/tb_vending_machine_seg.sv
// Directed bench for vending_machine_seg with fast tick/scan dividers
// (one tick and one scan every 4 sys_clk cycles). Expectations follow the
// VEND_CHANGE_EN setting of the build.
module tb_vending_machine_seg;

`ifdef VEND_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic       sys_clk;
  logic       reset;
  logic       c;
  logic [7:0] a;
  logic       cancel;
  logic       d;
  logic [7:0] change;
  logic       change_valid;
  logic [7:0] seg_out;
  logic [3:0] seg_sel;

  int errors = 0;
  int checks = 0;

  int         w_d, w_v, w_bad;
  logic [7:0] w_chg;

  vending_machine_seg #(
    .WIDTH    (8),
    .PRICE    (8'd150),
    .DIGITS   (4),
    .TICK_DIV (2),
    .SCAN_DIV (2)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .c            (c),
    .a            (a),
    .cancel       (cancel),
    .d            (d),
    .change       (change),
    .change_valid (change_valid),
    .seg_out      (seg_out),
    .seg_sel      (seg_sel)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Coin held long enough to cross the synchroniser and one tick.
  task automatic coin(input logic [7:0] val);
    a = val;
    c = 1'b1;
    idle(6);
    c = 1'b0;
  endtask

  // Observe outputs for n cycles: d/valid high-cycle counts, last qualified
  // change value, and any nonzero change while unqualified.
  task automatic watch(input int n);
    w_d = 0; w_v = 0; w_bad = 0; w_chg = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (d) w_d++;
      if (change_valid) begin
        w_v++;
        w_chg = change;
      end
      if (!change_valid && change != 8'd0) w_bad++;
    end
  endtask

  logic [7:0] seg_seen [4];
  logic [3:0] prev_sel;
  int         order_err;
  bit         found;

  initial begin
    reset = 1'b1; c = 1'b0; a = '0; cancel = 1'b0;
    idle(3);
    check("rst_d", d, 0);
    check("rst_change", change, 0);
    check("rst_valid", change_valid, 0);
    check("rst_seg_sel", seg_sel, 4'hF);
    check("rst_seg_out", seg_out, 8'hFF);
    reset = 1'b0;
    idle(1);
    check("first_scan_sel", seg_sel, 4'hE);
    check("first_scan_seg", seg_out, 8'hC0);
    idle(4);

    // 100 + 100 -> vend with 50 change
    coin(8'd100); idle(8); coin(8'd100); watch(30);
    check("vend_d_cycles", w_d, 4);
    check("vend_valid_cycles", w_v, CHG ? 4 : 0);
    check("vend_change", w_chg, CHG ? 50 : 0);
    check("vend_change_idle_zero", w_bad, 0);
    check("vend_tot_cleared", dut.tot, 0);

    // 50 then cancel -> refund 50
    coin(8'd50); idle(8);
    check("accum_tot50", dut.tot, 50);
    cancel = 1'b1; watch(20); cancel = 1'b0; idle(8);
    check("refund_d", w_d, 0);
    check("refund_valid_cycles", w_v, CHG ? 4 : 0);
    check("refund_change", w_chg, CHG ? 50 : 0);
    check("refund_tot_cleared", dut.tot, 0);

    // 100 + 200 saturates at 255 -> vend with 105 change
    coin(8'd100); idle(8); coin(8'd200); watch(30);
    check("sat_vend_d_cycles", w_d, 4);
    check("sat_vend_change", w_chg, CHG ? 105 : 0);
    idle(8);

    // coin and cancel on the same tick: refund includes the coin, saturated
    coin(8'd100); idle(8);
    a = 8'd200; c = 1'b1; cancel = 1'b1;
    watch(20);
    c = 1'b0; cancel = 1'b0; idle(8);
    check("coin_cancel_d", w_d, 0);
    check("coin_cancel_change", w_chg, CHG ? 255 : 0);
    check("coin_cancel_tot", dut.tot, 0);

    // coin held for 10 ticks credits once; display shows 0050
    a = 8'd50; c = 1'b1; idle(40); c = 1'b0; idle(8);
    check("held_coin_tot", dut.tot, 50);
    for (int k = 0; k < 4; k++) seg_seen[k] = 8'h00;
    order_err = 0;
    prev_sel = seg_sel;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (seg_sel != prev_sel && seg_sel != {prev_sel[2:0], prev_sel[3]}) order_err++;
      prev_sel = seg_sel;
      case (seg_sel)
        4'hE: seg_seen[0] = seg_out;
        4'hD: seg_seen[1] = seg_out;
        4'hB: seg_seen[2] = seg_out;
        4'h7: seg_seen[3] = seg_out;
        default: order_err++;
      endcase
    end
    check("disp_digit0", seg_seen[0], 8'hC0);
    check("disp_digit1", seg_seen[1], 8'h92);
    check("disp_digit2", seg_seen[2], 8'hC0);
    check("disp_digit3", seg_seen[3], 8'hC0);
    check("scan_order", order_err, 0);
    cancel = 1'b1; idle(20); cancel = 1'b0; idle(8);
    check("held_coin_cleared", dut.tot, 0);

    // reset in the middle of a vend
    coin(8'd100); idle(8); coin(8'd100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sys_clk);
      if (d) found = 1'b1;
    end
    check("vend_seen_before_reset", found, 1);
    reset = 1'b1;
    #1;
    check("midvend_rst_d", d, 0);
    check("midvend_rst_change", change, 0);
    check("midvend_rst_valid", change_valid, 0);
    check("midvend_rst_seg_sel", seg_sel, 4'hF);
    check("midvend_rst_seg_out", seg_out, 8'hFF);
    check("midvend_rst_tot", dut.tot, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check("midvend_first_scan_sel", seg_sel, 4'hE);
    watch(20);
    check("midvend_no_pulse", w_d, 0);
    check("midvend_no_change", w_v, 0);
    check("midvend_tot_lost", dut.tot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
